// File: rtl/fir_coef_regfile.sv
// fir_coef_regfile: decodes config byte writes into a shadow FIR coefficient set
// and commits it atomically to the active set at a sample boundary.
module fir_coef_regfile #(
  parameter int NTAPS = 8
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                WrEn,
  input  logic [2:0]          RegAddr,
  input  logic [7:0]          Din,
  input  logic                SampleEn,
  output logic [NTAPS*16-1:0] Coef,
  output logic [7:0]          NumTaps,
  output logic                Bypass,
  output logic                CommitPending,
  output logic                CfgErr
);
  localparam logic [7:0] NT = 8'(NTAPS);
  localparam int W = NTAPS * 16;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t         state_q, state_d;
  logic [7:0]     ptr_q, ptr_d, hold_q, hold_d, sh_taps_q, sh_taps_d, taps_q, taps_d;
  logic           half_q, half_d, sh_byp_q, sh_byp_d, byp_q, byp_d, err_q, err_d;
  logic [W-1:0]   shadow_q, shadow_d, coef_q, coef_d;
  logic           wr_idx, wr_coef, wr_taps, wr_ctrl, wr_word, ptr_ok, taps_ok, set_err, copy;
  always_comb begin
    wr_idx    = WrEn && RegAddr == 3'd0;
    wr_coef   = WrEn && RegAddr == 3'd1;
    wr_taps   = WrEn && RegAddr == 3'd2;
    wr_ctrl   = WrEn && RegAddr == 3'd3;
    ptr_ok    = ptr_q < NT;
    taps_ok   = Din != 8'd0 && Din <= NT;
    wr_word   = wr_coef && half_q && ptr_ok;
    ptr_d     = wr_idx ? Din : wr_word ? (ptr_q == 8'hFF ? ptr_q : ptr_q + 8'd1) : ptr_q;
    half_d    = wr_idx ? 1'b0 : wr_coef ? ~half_q : half_q;
    hold_d    = (wr_coef && !half_q) ? Din : hold_q;
    sh_taps_d = wr_taps ? (taps_ok ? Din : NT) : sh_taps_q;
    sh_byp_d  = wr_ctrl ? Din[1] : sh_byp_q;
    set_err   = (wr_coef && half_q && !ptr_ok) || (wr_taps && !taps_ok) || (WrEn && RegAddr[2]);
    err_d     = (wr_ctrl && Din[7]) ? 1'b0 : (set_err ? 1'b1 : err_q);
    shadow_d  = shadow_q;
    for (int k = 0; k < NTAPS; k++)
      if (wr_word && ptr_q == 8'(k)) shadow_d[16*k +: 16] = {Din, hold_q};
    state_d   = (state_q == IDLE) ? ((wr_ctrl && Din[0]) ? PENDING : IDLE) : (SampleEn ? IDLE : PENDING);
    // copy takes the shadow as registered before this edge, so same-edge writes wait for the next commit
    copy      = state_q == PENDING && SampleEn;
    coef_d    = copy ? shadow_q : coef_q;
    taps_d    = copy ? sh_taps_q : taps_q;
    byp_d     = copy ? sh_byp_q : byp_q;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      half_q    <= 1'b0;
      shadow_q  <= '0;
      sh_taps_q <= NT;
      sh_byp_q  <= 1'b1;
      coef_q    <= '0;
      taps_q    <= NT;
      byp_q     <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      half_q    <= half_d;
      shadow_q  <= shadow_d;
      sh_taps_q <= sh_taps_d;
      sh_byp_q  <= sh_byp_d;
      coef_q    <= coef_d;
      taps_q    <= taps_d;
      byp_q     <= byp_d;
      err_q     <= err_d;
    end
  end
  assign Coef          = coef_q;
  assign NumTaps       = taps_q;
  assign Bypass        = byp_q;
  assign CommitPending = state_q == PENDING;
  assign CfgErr        = err_q;
endmodule

// File: tb/tb_fir_coef_regfile.sv
// tb_fir_coef_regfile: table-driven directed checks of fir_coef_regfile plus reset-mid-operation sequence.
module tb_fir_coef_regfile;
  logic         CLK = 1'b0, RSTn = 1'b0, WrEn = 1'b0, SampleEn = 1'b0;
  logic [2:0]   RegAddr = '0;
  logic [7:0]   Din = '0;
  logic [127:0] Coef;
  logic [7:0]   NumTaps;
  logic         Bypass, CommitPending, CfgErr;
  int           nvec = 0, nbad = 0;
  typedef struct {
    logic         wr;
    logic [2:0]   addr;
    logic [7:0]   din;
    logic         smp;
    logic [127:0] coef;
    logic [7:0]   taps;
    logic         byp, pend, err;
  } vec_t;
  vec_t vq[$];
  localparam logic [127:0] C1 = 128'h0000_0000_0000_0000_0000_0000_5678_1234;
  localparam logic [127:0] C2 = 128'hBBAA_0000_0000_0000_0000_0000_5678_1234;
  localparam logic [127:0] C3 = 128'hBBAA_0000_0000_0000_2211_0000_5678_1234;
  localparam logic [127:0] C4 = 128'h0000_0000_0000_0000_0000_0000_0000_7766;
  fir_coef_regfile #(.NTAPS(8)) dut (
    .CLK(CLK), .RSTn(RSTn), .WrEn(WrEn), .RegAddr(RegAddr), .Din(Din), .SampleEn(SampleEn),
    .Coef(Coef), .NumTaps(NumTaps), .Bypass(Bypass), .CommitPending(CommitPending), .CfgErr(CfgErr)
  );
  always #5 CLK = ~CLK;
  task automatic add(input logic w, input logic [2:0] a, input logic [7:0] d, input logic s,
                     input logic [127:0] c, input logic [7:0] t, input logic b, input logic p, input logic e);
    vq.push_back('{w, a, d, s, c, t, b, p, e});
  endtask
  task automatic step(input logic w, input logic [2:0] a, input logic [7:0] d, input logic s);
    @(negedge CLK);
    WrEn = w; RegAddr = a; Din = d; SampleEn = s;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] c, input logic [7:0] t,
                     input logic b, input logic p, input logic e);
    nvec++;
    if (Coef !== c || NumTaps !== t || Bypass !== b || CommitPending !== p || CfgErr !== e) begin
      nbad++;
      $display("FAIL %s: got coef=%h taps=%0d byp=%b pend=%b err=%b, want coef=%h taps=%0d byp=%b pend=%b err=%b",
               name, Coef, NumTaps, Bypass, CommitPending, CfgErr, c, t, b, p, e);
    end
  endtask
  initial begin
    // load and commit
    add(1, 0, 8'h00, 0, 0, 8, 1, 0, 0);
    add(1, 1, 8'h34, 0, 0, 8, 1, 0, 0);
    add(1, 1, 8'h12, 0, 0, 8, 1, 0, 0);
    add(1, 1, 8'h78, 0, 0, 8, 1, 0, 0);
    add(1, 1, 8'h56, 0, 0, 8, 1, 0, 0);
    add(1, 2, 8'h02, 0, 0, 8, 1, 0, 0);
    add(1, 3, 8'h01, 0, 0, 8, 1, 1, 0);
    add(0, 0, 8'h00, 0, 0, 8, 1, 1, 0);
    add(0, 0, 8'h00, 1, C1, 2, 0, 0, 0);
    // overrun, then error clear
    add(1, 0, 8'h07, 0, C1, 2, 0, 0, 0);
    add(1, 1, 8'hAA, 0, C1, 2, 0, 0, 0);
    add(1, 1, 8'hBB, 0, C1, 2, 0, 0, 0);
    add(1, 1, 8'hCC, 0, C1, 2, 0, 0, 0);
    add(1, 1, 8'hDD, 0, C1, 2, 0, 0, 1);
    add(1, 3, 8'h80, 0, C1, 2, 0, 0, 0);
    // bad taps, bad address, commit
    add(1, 2, 8'h00, 0, C1, 2, 0, 0, 1);
    add(1, 5, 8'h3C, 0, C1, 2, 0, 0, 1);
    add(1, 3, 8'h01, 0, C1, 2, 0, 1, 1);
    add(0, 0, 8'h00, 1, C2, 8, 0, 0, 1);
    // commit request coincident with SampleEn while idle: no copy yet
    add(1, 3, 8'h83, 1, C2, 8, 0, 1, 0);
    add(1, 0, 8'h03, 0, C2, 8, 0, 1, 0);
    add(1, 1, 8'h11, 0, C2, 8, 0, 1, 0);
    // high byte on the copy edge: active keeps pre-write shadow
    add(1, 1, 8'h22, 1, C2, 8, 1, 0, 0);
    add(1, 3, 8'h01, 0, C2, 8, 1, 1, 0);
    add(1, 3, 8'h01, 0, C2, 8, 1, 1, 0);
    add(0, 0, 8'h00, 1, C3, 8, 0, 0, 0);
    // CTRL write during PENDING on the copy edge: copy uses pre-edge ShBypass
    add(1, 3, 8'h03, 0, C3, 8, 0, 1, 0);
    add(1, 3, 8'h00, 1, C3, 8, 1, 0, 0);
    add(1, 3, 8'h01, 0, C3, 8, 1, 1, 0);
    add(0, 0, 8'h00, 1, C3, 8, 0, 0, 0);
    repeat (2) @(negedge CLK);
    chk("reset", 0, 8, 1, 0, 0);
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 3, 8'h81, 1);
      chk("idle_sample", 0, 8, 1, 0, 0);
    end
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].wr, vq[i].addr, vq[i].din, vq[i].smp);
      chk($sformatf("vec%0d", i), vq[i].coef, vq[i].taps, vq[i].byp, vq[i].pend, vq[i].err);
    end
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h55, 0);
    step(1, 3, 8'h01, 0);
    chk("pre_reset_pending", C3, 8, 0, 1, 0);
    #2 RSTn = 1'b0;
    #1 chk("async_reset", 0, 8, 1, 0, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    step(1, 1, 8'h66, 0);
    step(1, 1, 8'h77, 0);
    step(1, 3, 8'h03, 0);
    chk("post_reset_pending", 0, 8, 1, 1, 0);
    step(0, 0, 8'h00, 1);
    chk("post_reset_commit", C4, 8, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/fir_coef_regfile.md
Name: fir_coef_regfile

Overview:
- Downstream consumer of the configuration byte stream (WrEn / RegAddr / 8-bit data) produced by the config passer.
- Decodes register writes into a shadow coefficient bank, tap count and control bits.
- Copies the shadow set atomically into the active set that drives the FIR datapath, at a sample boundary, on commit request.

Parameters:
NTAPS, 8, number of coefficient slots (1..255); each coefficient is a fixed 16 bits.

Ports:
CLK  input  1  clock
RSTn  input  1  reset, asynchronous, active-low
WrEn  input  1  write strobe from config passer; one byte per cycle while high
RegAddr  input  3  target register address
Din  input  8  write data byte
SampleEn  input  1  one-cycle strobe from the filter at each sample boundary
Coef  output  NTAPS*16  active coefficients, tap k at bits [16k+15:16k]
NumTaps  output  8  active tap count
Bypass  output  1  active bypass control
CommitPending  output  1  commit requested, not yet applied
CfgErr  output  1  sticky configuration error flag

Behaviour:
- All state updates occur on posedge CLK, and only when WrEn=1, except the commit path.
- Register map:
  - 0 INDEX: Ptr<=Din; HalfFlag<=0.
  - 1 COEF_DATA, HalfFlag=0: Hold<=Din; HalfFlag<=1.
  - 1 COEF_DATA, HalfFlag=1, Ptr<NTAPS: Shadow[Ptr]<={Din,Hold}; Ptr<=Ptr+1 (saturate at 255); HalfFlag<=0.
  - 1 COEF_DATA, HalfFlag=1, Ptr>=NTAPS: word dropped; CfgErr<=1; HalfFlag<=0; Ptr unchanged.
  - 2 TAPS: if 1<=Din<=NTAPS, ShNumTaps<=Din. Otherwise ShNumTaps<=NTAPS and CfgErr<=1.
  - 3 CTRL: bit1 -> ShBypass. bit0=1 -> commit request. bit7=1 -> clear CfgErr; clearing wins over any error set in the same cycle.
  - 4..7: no effect except CfgErr<=1.
- Coefficient byte order: low byte first, then high byte.
- Commit FSM, two states:
  - IDLE: a CTRL write with bit0=1 -> PENDING.
  - PENDING: on SampleEn=1, copy the shadow set to the active set (Shadow->Coef, ShNumTaps->NumTaps, ShBypass->Bypass), then -> IDLE.
  - A further commit request while PENDING is absorbed (stays PENDING).
  - CommitPending = (state==PENDING), registered.
- Simultaneous events:
  - CTRL commit write and SampleEn in the same cycle while IDLE: enter PENDING. Copy happens at the next SampleEn, not this one.
  - Shadow write and commit copy on the same edge: the active set receives the pre-write shadow value. The new value waits for the next commit.
  - A CTRL write during PENDING updates ShBypass. The copy uses the shadow value registered before that edge.
- Active outputs change only on a commit copy edge. They are never partially updated.
- Latency:
  - A shadow write is visible in the shadow 1 cycle after the WrEn edge.
  - Active outputs update on the SampleEn edge while PENDING.
- Reset (async, mid-operation included):
  - Shadow and Coef all 0; ShNumTaps=NumTaps=NTAPS; ShBypass=Bypass=1.
  - Ptr=0, HalfFlag=0, Hold=0; FSM IDLE; CommitPending=0; CfgErr=0.
  - A half-written coefficient is discarded.
- WrEn=0: Din and RegAddr are ignored; no state change apart from the commit path.

Test Plan:
- Reset then idle: Coef=0, NumTaps=8, Bypass=1, CommitPending=0, CfgErr=0. Outputs stay stable across 10 SampleEn pulses with no commit.
- Load and commit:
  - Stimulus: INDEX=0; COEF_DATA 34,12,78,56; TAPS=2; CTRL=0x01.
  - Check: CommitPending=1 and Coef unchanged until SampleEn.
  - Check after SampleEn: Coef[15:0]=0x1234, Coef[31:16]=0x5678, NumTaps=2, Bypass=0, CommitPending=0.
- Overrun:
  - Stimulus: INDEX=7; COEF_DATA AA,BB,CC,DD.
  - Check: Shadow[7]=0xBBAA; second word dropped; CfgErr=1.
  - Then CTRL=0x80: CfgErr=0.
- Bad TAPS and bad address:
  - TAPS=0: ShNumTaps=8 (visible after commit), CfgErr=1.
  - Write to addr 5: CfgErr=1; no other state change.
- Same-cycle collisions:
  - CTRL=0x01 coincident with SampleEn: no copy that cycle; copy at next SampleEn.
  - COEF high-byte write on the commit edge: active slot keeps its old value; new value appears after the next commit.
- Reset mid-operation: assert RSTn low after a low byte and while PENDING. All outputs return to reset values. A following single high byte is stored as a low byte (HalfFlag was cleared).
